// File: rtl/axis_variable_delay.sv
// AXI-Stream delay line: holds the stream back by a configurable number of samples
// using a circular buffer; a change of the requested delay flushes the buffer.
module axis_variable_delay #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ADDR_WIDTH       = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [ADDR_WIDTH-1:0]       cfg_data,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic [ADDR_WIDTH:0]         sts_fill,
    output logic [1:0]                  sts_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DA_MAX     = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] clamp_delay(input logic [ADDR_WIDTH-1:0] cfg);
        if (cfg >= DA_MAX) begin
            return DA_MAX;
        end else begin
            return cfg;
        end
    endfunction

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [ADDR_WIDTH-1:0]         cfg_src_r;
    logic [ADDR_WIDTH-1:0]         da_r;
    logic [ADDR_WIDTH-1:0]         wr_ptr_r;
    logic [ADDR_WIDTH-1:0]         rd_ptr_r;
    logic [ADDR_WIDTH-1:0]         wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0]         rd_ptr_nxt_s;
    logic [ADDR_WIDTH:0]           fill_r;
    logic [ADDR_WIDTH:0]           fill_upd_s;
    logic [ADDR_WIDTH:0]           fill_nxt_s;
    logic [AXIS_TDATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_r;
    logic [AXIS_TDATA_WIDTH-1:0]   rd_data_s;
    logic                          s_ready_r;
    logic                          m_valid_r;
    logic                          acc_s;
    logic                          xfer_s;
    logic                          flush_entry_s;

    assign acc_s  = s_axis_tvalid && s_ready_r;
    assign xfer_s = m_valid_r && m_axis_tready;

    // Occupancy, pointer and state update; a delay change empties everything on entry to flush.
    always_comb begin
        flush_entry_s = 1'b0;
        fill_upd_s    = fill_r;
        state_nxt_s   = ST_FLUSH;
        case ({acc_s, xfer_s})
            2'b10:   fill_upd_s = fill_r + (ADDR_WIDTH + 1)'(1);
            2'b01:   fill_upd_s = fill_r - (ADDR_WIDTH + 1)'(1);
            default: fill_upd_s = fill_r;
        endcase
        if ((state_r != ST_FLUSH) && (cfg_data != cfg_src_r)) begin
            flush_entry_s = 1'b1;
        end else begin
            flush_entry_s = 1'b0;
        end
        case (state_r)
            ST_FLUSH: state_nxt_s = ST_FILL;
            ST_FILL, ST_RUN: begin
                if (flush_entry_s) begin
                    state_nxt_s = ST_FLUSH;
                end else if (fill_upd_s > {1'b0, da_r}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            default: state_nxt_s = ST_FLUSH;
        endcase
        if (flush_entry_s) begin
            wr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
            rd_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
            fill_nxt_s   = {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + ADDR_WIDTH'(acc_s);
            rd_ptr_nxt_s = rd_ptr_r + ADDR_WIDTH'(xfer_s);
            fill_nxt_s   = fill_upd_s;
        end
    end

    // Head-of-queue read; a sample written into an empty buffer is forwarded directly.
    always_comb begin
        rd_data_s = mem_r[rd_ptr_nxt_s];
        if (acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            rd_data_s = s_axis_tdata;
        end else begin
            rd_data_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Sample storage; never written when full because the slave side is not ready then.
    always_ff @(posedge aclk) begin
        if (acc_s) begin
            mem_r[wr_ptr_r] <= s_axis_tdata;
        end
    end

    // Control registers and registered outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r   <= ST_FLUSH;
            cfg_src_r <= cfg_data;
            da_r      <= clamp_delay(cfg_data);
            wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r  <= {ADDR_WIDTH{1'b0}};
            fill_r    <= {(ADDR_WIDTH + 1){1'b0}};
            tdata_r   <= {AXIS_TDATA_WIDTH{1'b0}};
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (flush_entry_s) begin
                cfg_src_r <= cfg_data;
                da_r      <= clamp_delay(cfg_data);
            end else begin
                cfg_src_r <= cfg_src_r;
                da_r      <= da_r;
            end
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            fill_r    <= fill_nxt_s;
            tdata_r   <= rd_data_s;
            s_ready_r <= (state_nxt_s != ST_FLUSH) && (fill_nxt_s < FULL_COUNT);
            m_valid_r <= (state_nxt_s == ST_RUN);
        end
    end

    assign s_axis_tready = s_ready_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tdata  = tdata_r;
    assign sts_fill      = fill_r;
    assign sts_state     = state_r;

endmodule

// File: tb/tb_axis_variable_delay.sv
// Randomized bench for axis_variable_delay against a queue-based reference of the delay line.
module tb_axis_variable_delay;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] cfg_data;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic [AW:0]   sts_fill;
    logic [1:0]    sts_state;

    axis_variable_delay #(.AXIS_TDATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .areset(areset), .cfg_data(cfg_data),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .sts_fill(sts_fill), .sts_state(sts_state)
    );

    always #5 aclk = ~aclk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference: the queue holds accepted, untransferred samples in arrival order.
    logic [DW-1:0] ref_q [$];
    int            ref_da;
    logic [AW-1:0] ref_src;
    bit            ref_flush;
    bit            ref_in_rst;
    logic [DW-1:0] next_data = 32'd1;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (ref_flush) return 0;
        return (ref_q.size() > ref_da) ? 2 : 1;
    endfunction

    function automatic bit exp_ready();
        return !ref_flush && (ref_q.size() < DEPTH);
    endfunction

    function automatic void latch_delay();
        ref_src = cfg_data;
        ref_da  = (int'(cfg_data) > DEPTH - 1) ? DEPTH - 1 : int'(cfg_data);
    endfunction

    task automatic model_edge();
        bit acc;
        bit xfer;
        acc  = s_axis_tvalid && exp_ready();
        xfer = (exp_state() == 2) && m_axis_tready;
        ref_in_rst = areset;
        if (areset) begin
            ref_q.delete();
            ref_flush = 1'b1;
            latch_delay();
        end else if (ref_flush) begin
            ref_flush = 1'b0;
        end else begin
            if (xfer) void'(ref_q.pop_front());
            if (acc) begin
                ref_q.push_back(s_axis_tdata);
                next_data = next_data + 32'd1;
            end
            if (cfg_data != ref_src) begin
                ref_q.delete();
                ref_flush = 1'b1;
                latch_delay();
            end
        end
    endtask

    task automatic do_checks();
        check_value("state", 64'(sts_state), 64'(exp_state()));
        check_value("s_ready", 64'(s_axis_tready), 64'(exp_ready()));
        check_value("m_valid", 64'(m_axis_tvalid), 64'(exp_state() == 2));
        check_value("fill", 64'(sts_fill), 64'(ref_q.size()));
        if (exp_state() == 2) check_value("m_data", 64'(m_axis_tdata), 64'(ref_q[0]));
        if (ref_in_rst) check_value("rst_data", 64'(m_axis_tdata), 64'd0);
    endtask

    task automatic cycle();
        @(posedge aclk);
        model_edge();
        @(negedge aclk);
        do_checks();
        s_axis_tdata = next_data;
    endtask

    task automatic run(input int cycles, input int pv, input int pr);
        for (int i = 0; i < cycles; i++) begin
            s_axis_tvalid = ($urandom_range(0, 99) < pv);
            m_axis_tready = ($urandom_range(0, 99) < pr);
            cycle();
        end
    endtask

    initial begin
        areset        = 1'b1;
        cfg_data      = 10'd4;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tdata  = next_data;
        for (int i = 0; i < 3; i++) cycle();
        areset = 1'b0;

        // Basic delay of 4, then change to 8 while streaming.
        run(40, 100, 100);
        cfg_data = 10'd8;
        run(40, 100, 100);

        // Backpressure at delay 2 until full, then release and drain.
        cfg_data = 10'd2;
        run(1030, 100, 0);
        run(60, 100, 100);
        run(1100, 0, 100);

        // Clamp at maximum delay, then zero delay.
        cfg_data = 10'd1023;
        run(1100, 100, 100);
        cfg_data = 10'd0;
        run(30, 100, 100);
        run(30, 50, 50);

        // Sparse handshakes with occasional delay changes.
        for (int b = 0; b < 8; b++) begin
            cfg_data = AW'($urandom_range(0, 12));
            run(250, 50, 50);
        end

        // Reset pulse with seven samples held.
        cfg_data      = 10'd3;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 40 && ref_q.size() != 7; i++) cycle();
        check_value("fill_before_reset", 64'(sts_fill), 64'd7);
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        cycle();
        areset = 1'b0;
        run(60, 100, 100);
        run(200, 60, 40);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
